// File: rtl/pc_gen_if.sv
// Fetch-stage bundle between the front-end controller (master) and the PC generator (slave).
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic [1:0]       pc_src;
  logic [WIDTH-1:0] ImmOp;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] pc_inc;
  logic             redirect_pending;
  logic             misaligned;
  logic [WIDTH-1:0] fault_pc;

  modport master (
    output stall, pc_src, ImmOp, rs1_val,
    input  PC, pc_inc, redirect_pending, misaligned, fault_pc
  );

  modport slave (
    input  stall, pc_src, ImmOp, rs1_val,
    output PC, pc_inc, redirect_pending, misaligned, fault_pc
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential/branch/jalr/trap selection, stall with one-entry
// redirect buffer, and misaligned-target trapping with fault-PC capture.
module pc_gen #(
  parameter int unsigned    WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned    INC          = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam logic [1:0] SrcSeq  = 2'b00;
  localparam logic [1:0] SrcBr   = 2'b01;
  localparam logic [1:0] SrcJalr = 2'b10;
  localparam logic [1:0] SrcTrap = 2'b11;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_q, pend_d;
  logic             pend_fault_q, pend_fault_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] fault_pc_q, fault_pc_d;

  logic [WIDTH-1:0] seq_tgt, br_tgt, jr_sum, jr_tgt, tgt, resolved_tgt;
  logic             tgt_mis, redirect;

  always_comb begin
    seq_tgt = pc_q + WIDTH'(INC);
    br_tgt  = pc_q + bus.ImmOp;
    jr_sum  = bus.rs1_val + bus.ImmOp;
    jr_tgt  = {jr_sum[WIDTH-1:1], 1'b0};
    tgt     = seq_tgt;
    unique case (bus.pc_src)
      SrcSeq:  tgt = seq_tgt;
      SrcBr:   tgt = br_tgt;
      SrcJalr: tgt = jr_tgt;
      SrcTrap: tgt = TRAP_VECTOR;
      default: tgt = seq_tgt;
    endcase
    tgt_mis      = ((bus.pc_src == SrcBr) || (bus.pc_src == SrcJalr)) && (tgt[1:0] != 2'b00);
    resolved_tgt = tgt_mis ? TRAP_VECTOR : tgt;
    redirect     = (bus.pc_src != SrcSeq);
  end

  always_comb begin
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    pend_fault_d = pend_fault_q;
    mis_d        = 1'b0;
    fault_pc_d   = fault_pc_q;
    if (bus.stall) begin
      if (redirect && !pend_q) begin
        pend_d       = 1'b1;
        pend_tgt_d   = resolved_tgt;
        pend_fault_d = tgt_mis;
        if (tgt_mis) begin
          fault_pc_d = pc_q;
        end
      end else if (pend_q && (bus.pc_src == SrcTrap)) begin
        // A trap always supersedes whatever redirect is buffered.
        pend_tgt_d   = TRAP_VECTOR;
        pend_fault_d = 1'b0;
      end
    end else if (pend_q) begin
      pc_d         = (bus.pc_src == SrcTrap) ? TRAP_VECTOR : pend_tgt_q;
      pend_d       = 1'b0;
      pend_fault_d = 1'b0;
      mis_d        = pend_fault_q;
    end else begin
      pc_d = resolved_tgt;
      if (tgt_mis) begin
        mis_d      = 1'b1;
        fault_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      pend_fault_q <= 1'b0;
      mis_q        <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_fault_q <= pend_fault_d;
      mis_q        <= mis_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  assign bus.PC               = pc_q;
  assign bus.pc_inc           = seq_tgt;
  assign bus.redirect_pending = pend_q;
  assign bus.misaligned       = mis_q;
  assign bus.fault_pc         = fault_pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: stimulus pushes expected post-edge state,
// a negedge monitor pops and compares.
module tb_pc_gen;
  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
    logic [31:0] fpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  pc_gen_if #(.WIDTH(WIDTH)) bus ();

  pc_gen #(
    .WIDTH       (WIDTH),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .INC         (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, so compare whenever an expectation is queued.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("PC", bus.PC, e.pc);
      check("pc_inc", bus.pc_inc, e.pc + 32'd4);
      check("redirect_pending", {31'd0, bus.redirect_pending}, {31'd0, e.pend});
      check("misaligned", {31'd0, bus.misaligned}, {31'd0, e.mis});
      check("fault_pc", bus.fault_pc, e.fpc);
    end
  end

  task automatic step(input logic r, input logic s, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] rs1,
                      input logic [31:0] epc, input logic epend, input logic emis,
                      input logic [31:0] efpc);
    exp_t e;
    rst         = r;
    bus.stall   = s;
    bus.pc_src  = src;
    bus.ImmOp   = imm;
    bus.rs1_val = rs1;
    @(posedge clk);
    e.pc   = epc;
    e.pend = epend;
    e.mis  = emis;
    e.fpc  = efpc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    //    rst  stl src    ImmOp         rs1           PC            pend mis fault_pc
    // Reset then sequential fetch
    step(1, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    step(1, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0008, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_000C, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0010, 0, 0, 32'h0);
    // Branch with negative offset, then wrap of PC+4
    step(0, 0, 2'b01, 32'hFFFF_FFF0, 32'h0,       32'h0000_0000, 0, 0, 32'h0);
    step(0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0);
    // JALR bit0 clear, then misaligned JALR traps
    step(0, 0, 2'b10, 32'h10,       32'h1001,     32'h0000_1010, 0, 0, 32'h0);
    step(0, 0, 2'b10, 32'h10,       32'h1002,     32'h0000_0100, 0, 1, 32'h1010);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 32'h1010);
    // Misaligned branch
    step(0, 0, 2'b01, 32'h2,        32'h0,        32'h0000_0100, 0, 1, 32'h0104);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 32'h0104);
    // Move to 0x20, then stall buffering (first redirect wins)
    step(0, 0, 2'b01, 32'hFFFF_FF1C, 32'h0,       32'h0000_0020, 0, 0, 32'h0104);
    step(0, 1, 2'b01, 32'h40,       32'h0,        32'h0000_0020, 1, 0, 32'h0104);
    step(0, 1, 2'b01, 32'h80,       32'h0,        32'h0000_0020, 1, 0, 32'h0104);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0060, 0, 0, 32'h0104);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0064, 0, 0, 32'h0104);
    // Trap overrides pending branch while stalled
    step(0, 1, 2'b01, 32'h10,       32'h0,        32'h0000_0064, 1, 0, 32'h0104);
    step(0, 1, 2'b11, 32'h0,        32'h0,        32'h0000_0064, 1, 0, 32'h0104);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0100, 0, 0, 32'h0104);
    // Misaligned redirect captured under stall pulses after release
    step(0, 1, 2'b01, 32'h2,        32'h0,        32'h0000_0100, 1, 0, 32'h0100);
    step(0, 1, 2'b00, 32'h0,        32'h0,        32'h0000_0100, 1, 0, 32'h0100);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0100, 0, 1, 32'h0100);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 32'h0100);
    // Release cycle with trap takes TRAP_VECTOR over pending target
    step(0, 1, 2'b01, 32'h40,       32'h0,        32'h0000_0104, 1, 0, 32'h0100);
    step(0, 0, 2'b11, 32'h0,        32'h0,        32'h0000_0100, 0, 0, 32'h0100);
    // Reset mid-stall discards pending redirect
    step(0, 1, 2'b01, 32'h40,       32'h0,        32'h0000_0100, 1, 0, 32'h0100);
    step(1, 1, 2'b01, 32'h40,       32'h0,        32'h0000_0000, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 32'h0);
    step(0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0008, 0, 0, 32'h0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
